// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - processor write port and framebuffer RAM port of the arbiter
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  // Processor write request path
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Single-port framebuffer RAM; the address register lives in the arbiter
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Environment side: processor plus RAM
  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );

  // Arbiter side
  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter: scanout reads first, queued processor writes fill the gaps

// Small synchronous FIFO holding {addr, data} write requests in arrival order.
module vga_fb_arbiter_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage has no reset so it can map onto distributed RAM
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head_data = store[rd_ptr[PW-1:0]];
  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == (PW+1)'(DEPTH));
  assign empty     = (wr_ptr == rd_ptr);
endmodule

module vga_fb_arbiter #(
  parameter int H_VISIBLE  = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_VISIBLE  = 480,
  parameter int V_TOTAL    = 525,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    h_count,
  input  logic [9:0]                    v_count,
  vga_fb_arbiter_if.slave               bus,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_oob
);
  localparam int FB_SIZE = H_VISIBLE * V_VISIBLE;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [9:0]         hn;
  logic [9:0]         vn;
  logic               fetch;
  logic [ADDR_W-1:0]  fetch_addr;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_entry;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               head_in_range;

  // Coordinates of the pixel that will be on screen next cycle
  always_comb begin
    hn = h_count + 10'd1;
    vn = v_count;
    if (h_count == 10'(H_TOTAL - 1)) begin
      hn = '0;
      vn = (v_count == 10'(V_TOTAL - 1)) ? '0 : v_count + 10'd1;
    end
  end

  // A read is needed whenever the upcoming pixel is visible; it owns the RAM that cycle
  assign fetch      = (hn < 10'(H_VISIBLE)) && (vn < 10'(V_VISIBLE));
  assign fetch_addr = ADDR_W'(vn) * ADDR_W'(H_VISIBLE) + ADDR_W'(hn);

  // Writes queue up and only drain on cycles the scanout leaves free
  assign bus.wr_ready = !fifo_full && !rst;
  assign fifo_push    = bus.wr_valid && bus.wr_ready;
  assign fifo_pop     = !fetch && !fifo_empty;

  vga_fb_arbiter_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({bus.wr_addr, bus.wr_data}),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign head_addr     = head_entry[ENTRY_W-1:DATA_W];
  assign head_data     = head_entry[DATA_W-1:0];
  assign head_in_range = (head_addr < ADDR_W'(FB_SIZE));

  // RAM port register: scanout read, queued write, or hold the last address
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      pix_valid     <= 1'b0;
      err_oob       <= 1'b0;
    end else begin
      pix_valid  <= fetch;
      bus.mem_we <= 1'b0;
      if (fetch) begin
        bus.mem_addr <= fetch_addr;
      end else if (fifo_pop) begin
        if (head_in_range) begin
          bus.mem_addr  <= head_addr;
          bus.mem_wdata <= head_data;
          bus.mem_we    <= 1'b1;
        end else begin
          // Off-screen write is dropped but remembered until reset
          err_oob <= 1'b1;
        end
      end
    end
  end

  // The RAM returns data for the registered address within the following cycle
  assign pix_data = pix_valid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter: scanout pixels and RAM write order
module tb_vga_fb_arbiter;
  localparam int FB_SIZE = 640 * 480;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic [2:0] fifo_level;
  logic       err_oob;

  int n_chk  = 0;
  int n_fail = 0;
  logic acc;

  logic [7:0]  pq [$];
  logic [26:0] wq [$];
  logic [7:0]  shadow [int];

  // RAM model: preload value is addr[7:0] until a location is written
  bit         written [FB_SIZE];
  logic [7:0] wval    [FB_SIZE];

  vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus();

  vga_fb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .h_count    (h_count),
    .v_count    (v_count),
    .bus        (bus),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .fifo_level (fifo_level),
    .err_oob    (err_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we && int'(bus.mem_addr) < FB_SIZE) begin
      written[bus.mem_addr] <= 1'b1;
      wval[bus.mem_addr]    <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = (int'(bus.mem_addr) >= FB_SIZE) ? 8'h00 :
                         written[bus.mem_addr] ? wval[bus.mem_addr] : bus.mem_addr[7:0];

  function automatic logic [7:0] exp_pix(input int a);
    if (shadow.exists(a)) return shadow[a];
    return a[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at h=%0d v=%0d", name, act, exp, h_count, v_count);
    end
  endtask

  // One pixel clock: drive inputs after the edge, then log accepted writes and expected pixels
  task automatic step(input int h, input int v, input logic r, input logic wv,
                      input int wa, input logic [7:0] wd);
    int hn;
    int vn;
    @(posedge clk); #1;
    rst          = r;
    h_count      = 10'(h);
    v_count      = 10'(v);
    bus.wr_valid = wv;
    bus.wr_addr  = 19'(wa);
    bus.wr_data  = wd;
    @(negedge clk); #1;
    acc = wv && bus.wr_ready;
    if (acc && wa < FB_SIZE) begin
      wq.push_back({19'(wa), wd});
      shadow[wa] = wd;
    end
    hn = h + 1;
    vn = v;
    if (h == 799) begin
      hn = 0;
      vn = (v == 524) ? 0 : v + 1;
    end
    if (!r && hn < 640 && vn < 480) pq.push_back(exp_pix(vn * 640 + hn));
  endtask

  task automatic idle(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(h, v, 1'b0, 1'b0, 0, 8'h00);
  endtask

  // Monitor: every presented pixel and every RAM write is matched against the queues
  always @(negedge clk) begin
    if (pix_valid) begin
      if (pq.size() == 0) chk("pix_unexpected", 32'(pix_valid), 32'd0);
      else chk("pix_data", 32'(pix_data), 32'(pq.pop_front()));
    end else begin
      if (pq.size() != 0) chk("pix_missing", 32'(pix_valid), 32'd1);
      if (pq.size() != 0) void'(pq.pop_front());
      chk("pix_zero", 32'(pix_data), 32'd0);
    end
    if (bus.mem_we) begin
      chk("we_during_fetch", 32'(pix_valid), 32'd0);
      if (wq.size() == 0) chk("write_unexpected", 32'(bus.mem_addr), 32'hFFFFFFFF);
      else chk("write_order", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wq.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;

    // Reset held with a pending write: nothing may be accepted
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1'b1, 1'b1, 5, 8'h55);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_fifo_level", 32'(fifo_level), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_err_oob", 32'(err_oob), 32'd0);
    end
    step(0, 0, 1'b0, 1'b0, 0, 8'h00);
    chk("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    // Scanout addressing on lines 0 and 1, last visible line and first blank line
    for (int h = 1; h <= 799; h++) begin
      step(h, 0, 1'b0, 1'b0, 0, 8'h00);
      if (h == 3) chk("line0_pix3", 32'(pix_data), 32'd3);
      if (h == 700) chk("hblank_invalid", 32'(pix_valid), 32'd0);
    end
    for (int h = 0; h <= 799; h++) begin
      step(h, 1, 1'b0, 1'b0, 0, 8'h00);
      if (h == 5) chk("pix_h5_v1", 32'(pix_data), 32'h85);
    end
    idle(479, 0, 799);
    for (int h = 0; h <= 799; h++) begin
      step(h, 480, 1'b0, 1'b0, 0, 8'h00);
      if (h == 10) chk("vblank_invalid", 32'(pix_valid), 32'd0);
    end
    idle(524, 790, 799);
    step(0, 0, 1'b0, 1'b0, 0, 8'h00);
    chk("pix00_valid", 32'(pix_valid), 32'd1);
    chk("pix00_data", 32'(pix_data), 32'd0);
    idle(0, 1, 20);

    // Blanking drain: four writes pushed from h=640
    for (int h = 600; h <= 660; h++) begin
      step(h, 10, 1'b0, (h >= 640 && h <= 643), 10 + h - 640, 8'hA0 + 8'(h - 640));
      if (h == 641) chk("drain_we_641", 32'(bus.mem_we), 32'd0);
      if (h >= 642 && h <= 645) begin
        chk("drain_we", 32'(bus.mem_we), 32'd1);
        chk("drain_addr", 32'(bus.mem_addr), 32'(10 + h - 642));
        chk("drain_data", 32'(bus.mem_wdata), 32'(8'hA0 + 8'(h - 642)));
      end
    end
    for (int h = 5; h <= 16; h++) begin
      step(h, 0, 1'b0, 1'b0, 0, 8'h00);
      if (h == 10) chk("readback_10", 32'(pix_data), 32'hA0);
      if (h == 13) chk("readback_13", 32'(pix_data), 32'hA3);
    end

    // Backpressure: five writes attempted back to back from h=100
    begin
      int k = 0;
      idle(20, 90, 99);
      for (int h = 100; h <= 700; h++) begin
        step(h, 20, 1'b0, (k < 5), 1000 + k, 8'h10 + 8'(k));
        if (acc) k++;
        if (h == 104) begin
          chk("bp_full_ready", 32'(bus.wr_ready), 32'd0);
          chk("bp_full_level", 32'(fifo_level), 32'd4);
        end
        if (h == 200) chk("bp_no_drain_visible", 32'(bus.mem_we), 32'd0);
        if (h == 639) chk("bp_ready_639", 32'(bus.wr_ready), 32'd0);
        if (h == 640) chk("bp_ready_640", 32'(bus.wr_ready), 32'd1);
      end
      chk("bp_all_accepted", 32'(k), 32'd5);
    end

    // Out-of-range write is dropped and flagged, later writes still land
    idle(30, 640, 699);
    chk("oob_clear", 32'(err_oob), 32'd0);
    step(700, 30, 1'b0, 1'b1, FB_SIZE, 8'hEE);
    step(701, 30, 1'b0, 1'b1, 50, 8'h77);
    step(702, 30, 1'b0, 1'b0, 0, 8'h00);
    chk("oob_no_we", 32'(bus.mem_we), 32'd0);
    chk("oob_flag", 32'(err_oob), 32'd1);
    step(703, 30, 1'b0, 1'b0, 0, 8'h00);
    chk("oob_next_we", 32'(bus.mem_we), 32'd1);
    idle(30, 704, 760);

    // Push and pop together with two entries queued
    idle(40, 595, 599);
    step(600, 40, 1'b0, 1'b1, 3000, 8'hC0);
    step(601, 40, 1'b0, 1'b1, 3001, 8'hC1);
    idle(40, 602, 638);
    chk("pp_level_before", 32'(fifo_level), 32'd2);
    step(639, 40, 1'b0, 1'b1, 3002, 8'hC2);
    step(640, 40, 1'b0, 1'b0, 0, 8'h00);
    chk("pp_level_after", 32'(fifo_level), 32'd2);
    chk("pp_we", 32'(bus.mem_we), 32'd1);
    chk("pp_addr", 32'(bus.mem_addr), 32'd3000);
    idle(40, 641, 660);
    chk("oob_sticky", 32'(err_oob), 32'd1);

    // Reset in the middle of a drain discards the rest of the queue
    for (int h = 600; h <= 603; h++) step(h, 50, 1'b0, 1'b1, 2000 + h - 600, 8'hD0 + 8'(h - 600));
    idle(50, 604, 639);
    step(640, 50, 1'b1, 1'b0, 0, 8'h00);
    chk("mid_rst_we_first", 32'(bus.mem_we), 32'd1);
    step(641, 50, 1'b0, 1'b0, 0, 8'h00);
    wq.delete();
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
    chk("mid_rst_oob", 32'(err_oob), 32'd0);
    idle(50, 642, 680);

    chk("writes_pending", 32'(wq.size()), 32'd0);
    chk("pixels_pending", 32'(pq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
